// File: rtl/simd_pkg.sv
// Shared constants, instruction field layout and helpers for the SIMD issue stage.
package simd_pkg;

  localparam int VEC_W     = 256;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = 3;
  localparam int INST_W    = 16;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int DM_HI    = 11;
  localparam int DM_LO    = 9;
  localparam int IMMF_BIT = 8;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  localparam logic [3:0] OP_NOP = 4'd0;

  typedef enum logic [2:0] {
    DM_8  = 3'd0,
    DM_16 = 3'd1,
    DM_32 = 3'd2,
    DM_64 = 3'd3
  } dm_e;

  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] rd;
  } wb_tag_t;

  function automatic logic inst_is_nop(input logic [INST_W-1:0] inst);
    return inst[OPC_HI:OPC_LO] == OP_NOP;
  endfunction

  // With the immediate flag set the B operand comes from IMM, so rb is not a true source.
  function automatic logic inst_uses_rb(input logic [INST_W-1:0] inst);
    return !inst[IMMF_BIT];
  endfunction

endpackage

// File: rtl/simd_vregfile.sv
// 8 x 256-bit vector register file: two asynchronous read ports and a single
// write port shared by ALU writeback and preload (writeback wins).
module simd_vregfile
  import simd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [VEC_W-1:0]     wb_data,
  input  logic                 ld_en,
  input  logic [REG_IDX_W-1:0] ld_addr,
  input  logic [VEC_W-1:0]     ld_data,
  input  logic [REG_IDX_W-1:0] ra_addr,
  input  logic [REG_IDX_W-1:0] rb_addr,
  output logic [VEC_W-1:0]     ra_data,
  output logic [VEC_W-1:0]     rb_data
);

  logic [VEC_W-1:0] mem_q [NREG];
  logic [VEC_W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (wb_en) begin
      mem_d[wb_addr] = wb_data;
    end else if (ld_en) begin
      mem_d[ld_addr] = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/simd_issue_stage.sv
// Operand fetch and issue in front of SIMD_ALU: one-entry hold buffer, pending-bit
// scoreboard for RAW/WAW hazards, and a tag shift register timing ALU writeback.
module simd_issue_stage #(
  parameter int ALU_LAT = 2,
  parameter int NREG    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends on the matching valid.
  input  logic                           iq_valid,
  output logic                           iq_ready,
  input  logic [simd_pkg::INST_W-1:0]    iq_inst,
  input  logic [simd_pkg::REG_IDX_W-1:0] iq_rd,
  input  logic [simd_pkg::REG_IDX_W-1:0] iq_ra,
  input  logic [simd_pkg::REG_IDX_W-1:0] iq_rb,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [simd_pkg::REG_IDX_W-1:0] ld_addr,
  input  logic [simd_pkg::VEC_W-1:0]     ld_data,
  output logic [simd_pkg::INST_W-1:0]    alu_inst,
  output logic [simd_pkg::VEC_W-1:0]     alu_a,
  output logic [simd_pkg::VEC_W-1:0]     alu_b,
  input  logic [simd_pkg::VEC_W-1:0]     alu_out,
  output logic                           busy
);

  import simd_pkg::*;

  logic                 hold_v_q, hold_v_d;
  logic [INST_W-1:0]    hold_inst_q, hold_inst_d;
  logic [REG_IDX_W-1:0] hold_rd_q, hold_rd_d;
  logic [REG_IDX_W-1:0] hold_ra_q, hold_ra_d;
  logic [REG_IDX_W-1:0] hold_rb_q, hold_rb_d;
  logic [NREG-1:0]      pending_q, pending_d;
  wb_tag_t              tag_q [1:ALU_LAT];
  wb_tag_t              tag_d [1:ALU_LAT];
  logic [INST_W-1:0]    alu_inst_q, alu_inst_d;
  logic [VEC_W-1:0]     alu_a_q, alu_a_d;
  logic [VEC_W-1:0]     alu_b_q, alu_b_d;

  logic                 hold_nop;
  logic                 hazard;
  logic                 issue_fire;
  logic                 accept;
  logic                 wb_fire;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 ld_fire;
  logic                 tags_busy;
  logic [VEC_W-1:0]     rf_a, rf_b;

  assign hold_nop = inst_is_nop(hold_inst_q);
  assign hazard   = pending_q[hold_ra_q]
                  | (inst_uses_rb(hold_inst_q) & pending_q[hold_rb_q])
                  | (!hold_nop & pending_q[hold_rd_q]);
  assign issue_fire = hold_v_q && !hazard;
  assign iq_ready   = !hold_v_q || issue_fire;
  assign accept     = iq_valid && iq_ready;

  assign wb_fire  = tag_q[ALU_LAT].v;
  assign wb_rd    = tag_q[ALU_LAT].rd;
  assign ld_ready = !pending_q[ld_addr] && !wb_fire;
  assign ld_fire  = ld_valid && ld_ready;

  simd_vregfile u_rf (
    .clk     (clk),
    .rst_n   (rst),
    .wb_en   (wb_fire),
    .wb_addr (wb_rd),
    .wb_data (alu_out),
    .ld_en   (ld_fire),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ra_addr (hold_ra_q),
    .rb_addr (hold_rb_q),
    .ra_data (rf_a),
    .rb_data (rf_b)
  );

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_inst_d = hold_inst_q;
    hold_rd_d   = hold_rd_q;
    hold_ra_d   = hold_ra_q;
    hold_rb_d   = hold_rb_q;
    if (issue_fire) begin
      hold_v_d = 1'b0;
    end
    if (accept) begin
      hold_v_d    = 1'b1;
      hold_inst_d = iq_inst;
      hold_rd_d   = iq_rd;
      hold_ra_d   = iq_ra;
      hold_rb_d   = iq_rb;
    end

    // Set after clear so an issue would win over a same-edge writeback.
    pending_d = pending_q;
    if (wb_fire) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue_fire && !hold_nop) begin
      pending_d[hold_rd_q] = 1'b1;
    end

    tag_d[1].v  = issue_fire && !hold_nop;
    tag_d[1].rd = hold_rd_q;
    for (int i = 2; i <= ALU_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    alu_inst_d = issue_fire ? hold_inst_q : '0;
    alu_a_d    = issue_fire ? rf_a : alu_a_q;
    alu_b_d    = issue_fire ? rf_b : alu_b_q;

    tags_busy = 1'b0;
    for (int i = 1; i <= ALU_LAT; i++) begin
      tags_busy = tags_busy | tag_q[i].v;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q    <= 1'b0;
      hold_inst_q <= '0;
      hold_rd_q   <= '0;
      hold_ra_q   <= '0;
      hold_rb_q   <= '0;
      pending_q   <= '0;
      for (int i = 1; i <= ALU_LAT; i++) begin
        tag_q[i] <= '0;
      end
      alu_inst_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_inst_q <= hold_inst_d;
      hold_rd_q   <= hold_rd_d;
      hold_ra_q   <= hold_ra_d;
      hold_rb_q   <= hold_rb_d;
      pending_q   <= pending_d;
      tag_q       <= tag_d;
      alu_inst_q  <= alu_inst_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign alu_inst = alu_inst_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign busy     = hold_v_q || tags_busy;

  // The WAW check on rd makes a same-register issue/writeback collision unreachable.
  assert property (@(posedge clk) disable iff (!rst)
    !(issue_fire && !hold_nop && wb_fire && (wb_rd == hold_rd_q)));

endmodule
